// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues reads to a 1-cycle-latency
// instruction memory, and buffers returned words in an in-order queue.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic [ADDR_W-1:0]        IMEM_ADDR,
  output logic                     IMEM_EN,
  input  logic [31:0]              IMEM_DATA,
  input  logic                     REDIRECT,
  input  logic [31:0]              REDIRECT_PC,
  output logic [31:0]              INST,
  output logic [31:0]              INST_PC,
  output logic                     INST_VALID,
  input  logic                     INST_READY,
  output logic [$clog2(DEPTH):0]   OCCUPANCY
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc;
  logic [31:0]      pend_pc;
  logic             pend;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      tag_q  [DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W:0]   in_use;
  logic             unused_redirect_bits;

  assign unused_redirect_bits = ^REDIRECT_PC[1:0];

  // Credits cover both held entries and the in-flight fetch; a same-cycle pop
  // is deliberately not counted, so a response always has a free slot.
  assign in_use  = {1'b0, count} + {{CNT_W{1'b0}}, pend};
  assign IMEM_EN = RST & ~REDIRECT & (in_use < (CNT_W + 1)'(DEPTH));
  assign IMEM_ADDR = pc[ADDR_W-1:0];

  assign push = pend & ~REDIRECT;

  // Downstream handshake: a word transfers on any rising edge where
  // INST_VALID and INST_READY are both high; INST/INST_PC hold until then.
  assign INST_VALID = (count != '0);
  assign pop        = INST_VALID & INST_READY;
  assign INST       = INST_VALID ? data_q[rd_ptr] : 32'h0;
  assign INST_PC    = INST_VALID ? tag_q[rd_ptr]  : 32'h0;
  assign OCCUPANCY  = count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= 32'h0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else if (REDIRECT) begin
      // A head popped this cycle is already consumed downstream; flush the rest.
      pc     <= {REDIRECT_PC[31:2], 2'b00};
      pend   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (IMEM_EN) begin
        pend    <= 1'b1;
        pend_pc <= pc;
        pc      <= pc + 32'd4;
      end else begin
        pend <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr] <= IMEM_DATA;
      tag_q[wr_ptr]  <= pend_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory word at byte address a is
// 32'h1000_0000 + a; inputs change on the falling edge, outputs sampled 1ns later.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  IMEM_ADDR;
  logic        IMEM_EN;
  logic [31:0] IMEM_DATA = 32'h0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        INST_VALID;
  logic        INST_READY = 1'b0;
  logic [2:0]  OCCUPANCY;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.DEPTH(4), .ADDR_W(8), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .IMEM_ADDR(IMEM_ADDR), .IMEM_EN(IMEM_EN),
    .IMEM_DATA(IMEM_DATA), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .INST(INST), .INST_PC(INST_PC), .INST_VALID(INST_VALID),
    .INST_READY(INST_READY), .OCCUPANCY(OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  // Instruction memory model, 1-cycle read latency.
  always @(posedge CLK) begin
    if (IMEM_EN) IMEM_DATA <= 32'h1000_0000 + {24'h0, IMEM_ADDR};
  end

  // Hold reset for two cycles, release on a falling edge; returns at cycle 0 sample point.
  task automatic do_reset(input logic ready);
    @(negedge CLK);
    RST = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; INST_READY = ready;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RST = 1'b0; REDIRECT = 1'b1; INST_READY = 1'b1;
    #1;
    checks++;
    if (IMEM_EN !== 1'b0 || INST_VALID !== 1'b0 || INST !== 32'h0 || INST_PC !== 32'h0 ||
        OCCUPANCY !== 3'd0 || IMEM_ADDR !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: en=%b valid=%b inst=%h pc=%h occ=%0d addr=%h, want all 0",
               IMEM_EN, INST_VALID, INST, INST_PC, OCCUPANCY, IMEM_ADDR);
    end
    REDIRECT = 1'b0;
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    checks++;
    if (IMEM_EN !== 1'b1 || IMEM_ADDR !== 8'h00) begin
      errors++;
      $display("FAIL stream_cycle0: en=%b addr=%h, want en=1 addr=00", IMEM_EN, IMEM_ADDR);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK); #1;
      checks++;
      if (c == 1) begin
        if (INST_VALID !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency: cycle 1 valid=%b, want 0", INST_VALID);
        end
      end else if (INST_VALID !== 1'b1 || INST_PC !== 32'(4 * (c - 2)) ||
                   INST !== 32'h1000_0000 + 32'(4 * (c - 2)) || OCCUPANCY !== 3'd1) begin
        errors++;
        $display("FAIL stream_word: cycle %0d valid=%b pc=%h inst=%h occ=%0d, want 1 %h %h 1",
                 c, INST_VALID, INST_PC, INST, OCCUPANCY, 32'(4 * (c - 2)),
                 32'h1000_0000 + 32'(4 * (c - 2)));
      end
    end
  endtask

  task automatic test_backpressure;
    int pulses;
    int last;
    logic [7:0] addrs [4];
    pulses = 0;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(negedge CLK); #1; end
      if (IMEM_EN === 1'b1) begin
        if (pulses < 4) addrs[pulses] = IMEM_ADDR;
        pulses++;
      end
    end
    checks++;
    if (pulses != 4 || addrs[0] !== 8'h00 || addrs[1] !== 8'h04 || addrs[2] !== 8'h08 || addrs[3] !== 8'h0C) begin
      errors++;
      $display("FAIL bp_issue: pulses=%0d addrs=%h %h %h %h, want 4 pulses 00 04 08 0c",
               pulses, addrs[0], addrs[1], addrs[2], addrs[3]);
    end
    checks++;
    if (OCCUPANCY !== 3'd4 || IMEM_EN !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: occ=%0d en=%b, want occ=4 en=0", OCCUPANCY, IMEM_EN);
    end
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    @(negedge CLK);
    INST_READY = 1'b1;
    last = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (INST_VALID === 1'b1 && exp_q.size() > 0) begin
        checks++;
        if (INST_PC !== exp_q[0] || c - last > 2) begin
          errors++;
          $display("FAIL bp_drain: cycle %0d pc=%h gap=%0d, want pc=%h gap<=2", c, INST_PC, c - last, exp_q[0]);
        end
        void'(exp_q.pop_front());
        last = c;
      end
      @(negedge CLK);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: %0d words not delivered, want 0", exp_q.size());
    end
  endtask

  // Drops REDIRECT, then checks the next n cycles deliver exactly exp_q in order.
  task automatic test_post_redirect(input int n, input string name);
    int got;
    got = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK); REDIRECT = 1'b0; INST_READY = 1'b1; #1;
      if (INST_VALID === 1'b1) begin
        got++;
        checks++;
        if (exp_q.size() == 0 || INST_PC !== exp_q[0] || INST !== 32'h1000_0000 + {24'h0, exp_q[0][7:0]}) begin
          errors++;
          $display("FAIL %s_word: pc=%h inst=%h, want pc=%h", name, INST_PC, INST,
                   exp_q.size() > 0 ? exp_q[0] : 32'hx);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: got %0d words, %0d still expected", name, got, exp_q.size());
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    repeat (4) @(negedge CLK);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h43;
    #1;
    checks++;
    if (OCCUPANCY !== 3'd3 || IMEM_EN !== 1'b0) begin
      errors++;
      $display("FAIL redir_setup: occ=%0d en=%b, want occ=3 en=0", OCCUPANCY, IMEM_EN);
    end
    @(negedge CLK);
    REDIRECT = 1'b0; INST_READY = 1'b1;
    #1;
    checks++;
    if (INST_VALID !== 1'b0 || OCCUPANCY !== 3'd0 || IMEM_ADDR !== 8'h40 || IMEM_EN !== 1'b1) begin
      errors++;
      $display("FAIL redir_flush: valid=%b occ=%0d addr=%h en=%b, want 0 0 40 1",
               INST_VALID, OCCUPANCY, IMEM_ADDR, IMEM_EN);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h40 + 32'(4 * i));
    test_post_redirect(5, "redir");
  endtask

  task automatic test_wrap;
    logic [7:0] addrs [3];
    int n;
    do_reset(1'b1);
    repeat (2) @(negedge CLK);
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFC;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); REDIRECT = 1'b0; #1;
      if (IMEM_EN === 1'b1 && n < 3) begin addrs[n] = IMEM_ADDR; n++; end
    end
    checks++;
    if (n != 3 || addrs[0] !== 8'hFC || addrs[1] !== 8'h00 || addrs[2] !== 8'h04) begin
      errors++;
      $display("FAIL wrap_addr: n=%0d addrs=%h %h %h, want fc 00 04", n, addrs[0], addrs[1], addrs[2]);
    end
    do_reset(1'b1);
    @(negedge CLK);
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFC;
    exp_q.delete();
    exp_q.push_back(32'hFC); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    test_post_redirect(5, "wrap");
  endtask

  task automatic test_redirect_pop;
    do_reset(1'b1);
    repeat (4) @(negedge CLK);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
    #1;
    checks++;
    if (INST_VALID !== 1'b1 || INST_PC !== 32'h8) begin
      errors++;
      $display("FAIL rpop_head: valid=%b pc=%h, want 1 00000008", INST_VALID, INST_PC);
    end
    @(negedge CLK); REDIRECT = 1'b0; #1;
    checks++;
    if (INST_VALID !== 1'b0 || OCCUPANCY !== 3'd0) begin
      errors++;
      $display("FAIL rpop_flush: valid=%b occ=%0d pc=%h, want 0 0", INST_VALID, OCCUPANCY, INST_PC);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(4 * i));
    test_post_redirect(5, "rpop");
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (OCCUPANCY !== 3'd2 || INST_VALID !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: occ=%0d valid=%b, want 2 1", OCCUPANCY, INST_VALID);
    end
    #1;
    RST = 1'b0;
    #1;
    checks++;
    if (INST_VALID !== 1'b0 || IMEM_EN !== 1'b0 || OCCUPANCY !== 3'd0 || IMEM_ADDR !== 8'h00) begin
      errors++;
      $display("FAIL areset_drop: valid=%b en=%b occ=%0d addr=%h, want 0 0 0 00",
               INST_VALID, IMEM_EN, OCCUPANCY, IMEM_ADDR);
    end
    @(negedge CLK);
    RST = 1'b1; INST_READY = 1'b1;
    #1;
    checks++;
    if (IMEM_EN !== 1'b1 || IMEM_ADDR !== 8'h00) begin
      errors++;
      $display("FAIL areset_refetch: en=%b addr=%h, want 1 00", IMEM_EN, IMEM_ADDR);
    end
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (INST_VALID !== 1'b1 || INST_PC !== 32'h0 || INST !== 32'h1000_0000) begin
      errors++;
      $display("FAIL areset_first: valid=%b pc=%h inst=%h, want 1 0 10000000", INST_VALID, INST_PC, INST);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_pop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
